// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for mem_bus_arbiter (FSM states, master ids, latched request).
package mem_arb_pkg;
    localparam int ARB_DW = 32;
    localparam int ARB_AW = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic {MST_IMEM, MST_DMEM} arb_mst_t;
    typedef struct packed {
        logic [ARB_AW-1:0]   addr;
        logic                we;
        logic [ARB_DW/8-1:0] wmask;
        logic [ARB_DW-1:0]   wdata;
    } arb_req_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selection between imem and dmem requests.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise dmem has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     i_req_vld,
    input  logic     d_req_vld,
`ifdef MEM_ARB_RR_EN
    input  arb_mst_t last_granted,
`endif
    output logic     gnt_i,
    output logic     gnt_d
);
`ifdef MEM_ARB_RR_EN
    // On contention the master that did not win last time goes next.
    assign gnt_d = d_req_vld && (!i_req_vld || last_granted == MST_IMEM);
`else
    assign gnt_d = d_req_vld;
`endif
    assign gnt_i = i_req_vld && !gnt_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-outstanding arbiter merging imem and dmem masters onto one slave port.
// MEM_ARB_RR_EN enables round-robin arbitration; default is fixed dmem-over-imem priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_vld,
    output logic                    i_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_rsp_vld,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req_vld,
    output logic                    d_req_rdy,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_rsp_vld,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    s_req_vld,
    input  logic                    s_req_rdy,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic                    s_we,
    output logic [DATA_WIDTH/8-1:0] s_wmask,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic                    s_rsp_vld,
    input  logic [DATA_WIDTH-1:0]   s_rdata
);
    arb_state_t state;
    arb_mst_t   owner;
    arb_req_t   req;
    logic       gnt_i, gnt_d;
`ifdef MEM_ARB_RR_EN
    arb_mst_t   last;
`endif

    mem_arb_pick u_pick (
        .i_req_vld    (i_req_vld),
        .d_req_vld    (d_req_vld),
`ifdef MEM_ARB_RR_EN
        .last_granted (last),
`endif
        .gnt_i        (gnt_i),
        .gnt_d        (gnt_d)
    );

    assign i_req_rdy = state == ARB_IDLE && gnt_i;
    assign d_req_rdy = state == ARB_IDLE && gnt_d;
    assign s_req_vld = state == ARB_ISSUE;
    assign s_addr    = req.addr;
    assign s_we      = req.we;
    assign s_wmask   = req.wmask;
    assign s_wdata   = req.wdata;
    assign i_rsp_vld = state == ARB_RESP && owner == MST_IMEM;
    assign d_rsp_vld = state == ARB_RESP && owner == MST_DMEM;

    // A slave response outside WAIT is a protocol error and simply ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            owner   <= MST_IMEM;
            req     <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: if (i_req_rdy || d_req_rdy) begin
                    owner <= d_req_rdy ? MST_DMEM : MST_IMEM;
                    req   <= d_req_rdy ? arb_req_t'{addr: d_addr, we: d_we, wmask: d_wmask, wdata: d_wdata}
                                       : arb_req_t'{addr: i_addr, we: 1'b0, wmask: '0, wdata: '0};
                    state <= ARB_ISSUE;
                end
                ARB_ISSUE: if (s_req_rdy) state <= ARB_WAIT;
                ARB_WAIT: if (s_rsp_vld) begin
                    if (owner == MST_DMEM) d_rdata <= s_rdata;
                    else i_rdata <= s_rdata;
                    state <= ARB_RESP;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last <= MST_DMEM;
        else if (i_req_rdy || d_req_rdy) last <= d_req_rdy ? MST_DMEM : MST_IMEM;
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized self-checking bench for mem_bus_arbiter.
// Expected grants follow MEM_ARB_RR_EN the same way the design build does.
module tb_mem_bus_arbiter;
    logic        clk = 0, rst = 0;
    logic        i_req_vld = 0, i_req_rdy, i_rsp_vld;
    logic [31:0] i_addr = 0, i_rdata;
    logic        d_req_vld = 0, d_req_rdy, d_we = 0, d_rsp_vld;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic [3:0]  d_wmask = 0, s_wmask;
    logic        s_req_vld, s_req_rdy = 0, s_we, s_rsp_vld = 0;
    logic [31:0] s_addr, s_wdata, s_rdata = 0;
    int          errs = 0, checks = 0;
    bit          last_d = 1;
    logic [31:0] i_rd_m = 0, d_rd_m = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_vld(i_req_vld), .i_req_rdy(i_req_rdy), .i_addr(i_addr),
        .i_rsp_vld(i_rsp_vld), .i_rdata(i_rdata),
        .d_req_vld(d_req_vld), .d_req_rdy(d_req_rdy), .d_addr(d_addr),
        .d_we(d_we), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rsp_vld(d_rsp_vld), .d_rdata(d_rdata),
        .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_addr(s_addr),
        .s_we(s_we), .s_wmask(s_wmask), .s_wdata(s_wdata),
        .s_rsp_vld(s_rsp_vld), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arbitration rule: returns 1 when dmem should win.
    function automatic bit pick_d(input bit iv, input bit dv, input bit ld);
`ifdef MEM_ARB_RR_EN
        if (iv && dv) return !ld;
`endif
        return dv;
    endfunction

    task automatic idle_outputs(input string tag);
        check({tag, "_s_vld"}, s_req_vld, 0);
        check({tag, "_i_rsp"}, i_rsp_vld, 0);
        check({tag, "_d_rsp"}, d_rsp_vld, 0);
        check({tag, "_i_rdata"}, i_rdata, i_rd_m);
        check({tag, "_d_rdata"}, d_rdata, d_rd_m);
    endtask

    // One full transaction; called with the DUT in IDLE just after a falling edge.
    task automatic txn(input bit iv, input bit dv, input logic [31:0] ia, input logic [31:0] da,
                       input bit we, input logic [3:0] wm, input logic [31:0] wd,
                       input int stall, input int lat, input bit keep, input logic [31:0] rd);
        bit win_d;
        logic [31:0] ea, ewd;
        logic [3:0]  ewm;
        bit          ewe;
        i_req_vld = iv; d_req_vld = dv; i_addr = ia; d_addr = da;
        d_we = we; d_wmask = wm; d_wdata = wd;
        win_d = pick_d(iv, dv, last_d);
        last_d = win_d;
        ea = win_d ? da : ia;
        ewe = win_d && we;
        ewm = win_d ? wm : 4'h0;
        ewd = win_d ? wd : 32'h0;
        #1;
        check("grant_i", i_req_rdy, !win_d);
        check("grant_d", d_req_rdy, win_d);
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin i_req_vld = 0; d_req_vld = 0; end
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_wmask = 4'($urandom); d_we = 1'($urandom);
        for (int k = 0; k <= stall; k++) begin
            s_req_rdy = (k == stall);
            #1;
            check("issue_vld", s_req_vld, 1);
            check("issue_addr", s_addr, ea);
            check("issue_we", s_we, ewe);
            check("issue_wmask", s_wmask, ewm);
            check("issue_wdata", s_wdata, ewd);
            check("issue_rdy", {i_req_rdy, d_req_rdy}, 0);
            @(negedge clk);
        end
        s_req_rdy = 0;
        #1;
        check("wait_s_vld", s_req_vld, 0);
        for (int k = 0; k < lat; k++) begin
            check("wait_rdy", {i_req_rdy, d_req_rdy}, 0);
            check("wait_rsp", {i_rsp_vld, d_rsp_vld}, 0);
            @(negedge clk);
            #1;
        end
        s_rsp_vld = 1; s_rdata = rd;
        @(negedge clk);
        s_rsp_vld = 0; s_rdata = $urandom;
        if (win_d) d_rd_m = rd; else i_rd_m = rd;
        #1;
        check("rsp_i", i_rsp_vld, !win_d);
        check("rsp_d", d_rsp_vld, win_d);
        check("rsp_i_rdata", i_rdata, i_rd_m);
        check("rsp_d_rdata", d_rdata, d_rd_m);
        check("rsp_rdy", {i_req_rdy, d_req_rdy}, 0);
        @(negedge clk);
        #1;
        check("post_rsp", {i_rsp_vld, d_rsp_vld}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        idle_outputs("reset");
        check("reset_rdy", {i_req_rdy, d_req_rdy}, 0);
        check("reset_s", {s_addr, s_we, s_wmask, s_wdata}, 0);
        rst = 1;
        @(negedge clk);
        #1;
        check("idle_rdy", {i_req_rdy, d_req_rdy}, 0);

        txn(1, 0, 32'h0000_0010, 0, 0, 0, 0, 0, 0, 0, 32'h0010_0093);
        txn(0, 1, 0, 32'h0000_0100, 1, 4'b0011, 32'hDEAD_BEEF, 3, 2, 0, 32'h1234_5678);

        for (int n = 0; n < 4; n++)
            txn(1, 1, $urandom, $urandom, 1'($urandom), 4'($urandom), $urandom,
                0, 0, n < 3, $urandom);

        txn(0, 1, 32'h40, 32'h80, 0, 0, 0, 1, 20, 1, 32'hCAFE_0001);
        txn(0, 1, 32'h44, 32'h84, 1, 4'hF, 32'h5555_AAAA, 0, 0, 0, 32'hCAFE_0002);

        s_rsp_vld = 1; s_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        s_rsp_vld = 0;
        #1;
        idle_outputs("stray_rsp");
        @(negedge clk);
        #1;
        idle_outputs("stray_rsp2");

        for (int n = 0; n < 40; n++) begin
            int sel = $urandom_range(1, 3);
            txn(sel[0], sel[1], $urandom, $urandom, 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom), $urandom);
        end
        i_req_vld = 0; d_req_vld = 0;

        d_req_vld = 1; d_addr = 32'h200; d_we = 0;
        last_d = 1;
        @(posedge clk);
        @(negedge clk);
        d_req_vld = 0; s_req_rdy = 1;
        @(negedge clk);
        s_req_rdy = 0;
        #2 rst = 0;
        i_rd_m = 0; d_rd_m = 0; last_d = 1;
        #1;
        idle_outputs("async_rst");
        check("async_rst_s", {s_addr, s_we, s_wmask, s_wdata}, 0);
        @(negedge clk);
        rst = 1;
        s_rsp_vld = 1; s_rdata = 32'h7777_7777;
        @(negedge clk);
        s_rsp_vld = 0;
        #1;
        idle_outputs("late_rsp");
        @(negedge clk);
        #1;
        idle_outputs("late_rsp2");

        txn(1, 1, 32'h300, 32'h304, 0, 0, 0, 0, 1, 1, 32'hA1A1_A1A1);
        txn(1, 1, 32'h308, 32'h30C, 1, 4'h1, 32'h0F0F_0F0F, 1, 0, 0, 32'hB2B2_B2B2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
